// File: rtl/ahb_crc32_pkg.sv
// Shared definitions for the AHB-Lite CRC-32 slave: register offsets, polynomial,
// AHB encodings, FSM state type and a lane-strobe helper.
package ahb_crc32_pkg;

  // Register word index, i.e. HADDR[3:2]
  localparam logic [1:0] RegCtrl   = 2'd0;  // 0x0
  localparam logic [1:0] RegData   = 2'd1;  // 0x4
  localparam logic [1:0] RegResult = 2'd2;  // 0x8
  localparam logic [1:0] RegSeed   = 2'd3;  // 0xC

  // IEEE 802.3 polynomial, bit-reflected
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  typedef enum logic [1:0] {
    StIdle,
    StProc,
    StErr1,
    StErr2
  } state_e;

  // Little-endian byte lanes touched by an aligned access
  function automatic logic [3:0] byte_strb(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      HsizeByte: strb = 4'b0001 << lo;
      HsizeHalf: strb = lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_crc32_slave_step.sv
// Combinational reflected CRC-32 update over one byte, unrolled over its 8 bits.
module crc32_byte_step
  import ahb_crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [31:0] crc_out
);

  // Bit-serial LFSR unrolled eight times, LSB first
  always_comb begin
    crc_out = crc_in ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CrcPoly) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/ahb_crc32_slave.sv
// AHB-Lite slave folding DATA writes into a running CRC-32 at one byte per cycle.
// Optional done interrupt enabled by defining AHB_CRC32_IRQ_EN.
module ahb_crc32_slave
  import ahb_crc32_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter logic [31:0] SEED_RST = 32'hFFFF_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
`ifdef AHB_CRC32_IRQ_EN
  ,
  output logic        crc_irq
`endif
);

  state_e      state_q, state_d;
  logic        dp_valid_q, dp_write_q, dp_err_q;
  logic [1:0]  dp_reg_q, dp_lo_q;
  logic [2:0]  dp_size_q;
  logic [31:0] crc_q, seed_q, seed_d, stage_q, crc_next;
  logic [2:0]  cnt_q;

  logic [ADDR_W-1:0] addr;
  logic accept, addr_err, busy, last, stall_type;
  logic dp_done, wr_en, data_wr, init_wr, seed_wr, irq_clr;

  assign addr   = HADDR[ADDR_W-1:0];
  assign accept = HSEL & HREADY & HTRANS[1];
  assign busy   = (state_q == StProc);
  assign last   = busy & (cnt_q == 3'd1);

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_W], HTRANS[0]};

  // Address-phase error classification
  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > HsizeWord) addr_err = 1'b1;
    if (HSIZE == HsizeHalf && addr[0]) addr_err = 1'b1;
    if (HSIZE == HsizeWord && addr[1:0] != 2'b00) addr_err = 1'b1;
    if (HWRITE && addr[3:2] == RegResult) addr_err = 1'b1;
  end

  // Data-phase accesses that must see the finished CRC wait out PROC
  assign stall_type = (dp_reg_q == RegData) | (dp_reg_q == RegResult) |
                      ((dp_reg_q == RegCtrl) & dp_write_q & HWDATA[0]);

  // Address-phase capture for the following data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_err_q   <= 1'b0;
      dp_reg_q   <= 2'd0;
      dp_lo_q    <= 2'd0;
      dp_size_q  <= 3'd0;
    end else if (HREADY) begin
      dp_valid_q <= accept;
      if (accept) begin
        dp_write_q <= HWRITE;
        dp_err_q   <= addr_err;
        dp_reg_q   <= addr[3:2];
        dp_lo_q    <= addr[1:0];
        dp_size_q  <= HSIZE;
      end
    end
  end

  // Bus response outputs
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      StErr2:  HRESP = 1'b1;
      default: if (dp_valid_q && (dp_err_q || (busy && stall_type))) HREADYOUT = 1'b0;
    endcase
  end

  assign dp_done = dp_valid_q & ~dp_err_q & HREADYOUT & ~HRESP;
  assign wr_en   = dp_done & dp_write_q;
  assign data_wr = wr_en & (dp_reg_q == RegData);
  assign init_wr = wr_en & (dp_reg_q == RegCtrl) & HWDATA[0];
  assign irq_clr = wr_en & (dp_reg_q == RegCtrl) & HWDATA[2];
  assign seed_wr = wr_en & (dp_reg_q == RegSeed);

  // Read data mux, only meaningful when HREADYOUT is high
  always_comb begin
    HRDATA = 32'h0;
    if (dp_valid_q && !dp_write_q && !dp_err_q) begin
      case (dp_reg_q)
        RegCtrl:   HRDATA = {30'h0, busy, 1'b0};
        RegResult: HRDATA = ~crc_q;
        RegSeed:   HRDATA = seed_q;
        default:   HRDATA = 32'h0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state; an error arriving while PROC runs is held until IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (data_wr)                     state_d = StProc;
        else if (accept && addr_err)     state_d = StErr1;
        else if (dp_valid_q && dp_err_q) state_d = StErr1;
      end
      StProc:  if (last) state_d = StIdle;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = (accept && addr_err) ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  crc32_byte_step u_step (
    .crc_in   (crc_q),
    .data_byte(stage_q[7:0]),
    .crc_out  (crc_next)
  );

  // SEED byte-lane merge
  always_comb begin
    logic [3:0] strb;
    strb   = byte_strb(dp_size_q, dp_lo_q);
    seed_d = seed_q;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) seed_d[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // CRC, seed and byte staging; INIT never coincides with PROC since it stalls
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      crc_q   <= SEED_RST;
      seed_q  <= SEED_RST;
      stage_q <= 32'h0;
      cnt_q   <= 3'd0;
    end else begin
      if (init_wr)   crc_q <= seed_q;
      else if (busy) crc_q <= crc_next;
      if (seed_wr) seed_q <= seed_d;
      if (data_wr) begin
        stage_q <= HWDATA >> {dp_lo_q, 3'b000};
        case (dp_size_q)
          HsizeByte: cnt_q <= 3'd1;
          HsizeHalf: cnt_q <= 3'd2;
          default:   cnt_q <= 3'd4;
        endcase
      end else if (busy) begin
        stage_q <= stage_q >> 8;
        cnt_q   <= cnt_q - 3'd1;
      end
    end
  end

`ifdef AHB_CRC32_IRQ_EN
  logic irq_q;
  // Done interrupt: set on PROC completion, set beats a simultaneous clear
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)       irq_q <= 1'b0;
    else if (last)    irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end
  assign crc_irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
`endif

endmodule

// File: tb/tb_ahb_crc32_slave.sv
// Scoreboard bench for ahb_crc32_slave: driver pushes expected responses,
// a negedge monitor pops and compares on each completed data phase.
module tb_ahb_crc32_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        hready, hreadyout, hresp;
  logic [31:0] hrdata;
`ifdef AHB_CRC32_IRQ_EN
  logic        crc_irq;
`endif

  assign hready = hreadyout;
  always #5 clk = ~clk;

  ahb_crc32_slave dut (
    .HCLK     (clk),
    .HRESET   (rst),
    .HSEL     (hsel),
    .HREADY   (hready),
    .HTRANS   (htrans),
    .HSIZE    (hsize),
    .HWRITE   (hwrite),
    .HADDR    (haddr),
    .HWDATA   (hwdata),
    .HREADYOUT(hreadyout),
    .HRESP    (hresp),
    .HRDATA   (hrdata)
`ifdef AHB_CRC32_IRQ_EN
    ,
    .crc_irq  (crc_irq)
`endif
  );

  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: counts wait states of each data phase and checks on completion
  initial begin : monitor
    bit   in_dp;
    int   waits;
    exp_t e;
    in_dp = 0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_dp = 0;
      end else begin
        if (in_dp) begin
          if (hreadyout) begin
            in_dp = 0;
            if (sb.size() == 0) begin
              cmp("unexpected_response", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              cmp({e.name, ".waits"}, 32'(waits), 32'(e.waits));
              cmp({e.name, ".resp"}, {31'h0, hresp}, {31'h0, e.resp});
              if (e.chk_data) cmp({e.name, ".rdata"}, hrdata, e.data);
            end
          end else begin
            waits++;
          end
        end
        if (hsel && hready && htrans[1]) begin
          in_dp = 1;
          waits = 0;
        end
      end
    end
  end

  task automatic push(input string name, input logic chk, input logic [31:0] data,
                      input logic resp, input int waits);
    exp_t e;
    e.name = name;
    e.chk_data = chk;
    e.data = data;
    e.resp = resp;
    e.waits = waits;
    sb.push_back(e);
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic go_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 64; i++) begin
      if (hreadyout) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    cmp({name, ".timeout"}, 32'd1, 32'd0);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input string name, input logic chk,
                      input logic [31:0] exp, input logic resp, input int waits);
    push(name, chk, exp, resp, waits);
    addr_phase(wr, a, sz);
    @(posedge clk); #1;
    go_idle();
    hwdata = wd;
    wait_done(name);
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                    input string name, input int waits);
    xfer(1'b1, a, sz, wd, name, 1'b0, 32'h0, 1'b0, waits);
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp,
                    input int waits);
    xfer(1'b0, a, 3'd2, 32'h0, name, 1'b1, exp, 1'b0, waits);
  endtask

  task automatic err(input logic w, input logic [31:0] a, input logic [2:0] sz, input string name);
    xfer(w, a, sz, 32'h0, name, 1'b0, 32'h0, 1'b1, 1);
  endtask

  // Word write to DATA pipelined with a RESULT read in its data phase
  task automatic wr_rd(input logic [31:0] wd, input string name, input logic [31:0] exp,
                       input int waits);
    push({name, ".wr"}, 1'b0, 32'h0, 1'b0, 0);
    push({name, ".rd"}, 1'b1, exp, 1'b0, waits);
    addr_phase(1'b1, 32'h4, 3'd2);
    @(posedge clk); #1;
    hwdata = wd;
    addr_phase(1'b0, 32'h8, 3'd2);
    @(posedge clk); #1;
    go_idle();
    wait_done(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst    = 1'b1;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    haddr  = 32'h0;
    hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.hreadyout", {31'h0, hreadyout}, 32'd1);
    cmp("rst.hresp", {31'h0, hresp}, 32'd0);
    cmp("rst.hrdata", hrdata, 32'h0);
`ifdef AHB_CRC32_IRQ_EN
    cmp("rst.irq", {31'h0, crc_irq}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    rd(32'h0, "rst_ctrl", 32'h0000_0000, 0);
    rd(32'hC, "rst_seed", 32'hFFFF_FFFF, 0);
    rd(32'h8, "rst_result", 32'h0000_0000, 0);

    // "123456789" as word, word, byte
    wr(32'h0, 3'd2, 32'h1, "init_a", 0);
    wr(32'h4, 3'd2, 32'h3433_3231, "w1234", 0);
    wr(32'h4, 3'd2, 32'h3837_3635, "w5678", 3);
    wr(32'h4, 3'd0, 32'h0000_0039, "b9", 3);
    rd(32'h8, "result_wwb", 32'hCBF4_3926, 0);

    // Same message as nine lane-correct byte writes
    wr(32'h0, 3'd2, 32'h1, "init_b", 0);
    for (int i = 0; i < 9; i++) begin
      logic [31:0] d;
      d = (32'h31 + 32'(i)) << (8 * (i % 4));
      wr(32'h4 + 32'(i % 4), 3'd0, d, $sformatf("byte%0d", i), 0);
    end
    rd(32'h8, "result_bytes", 32'hCBF4_3926, 0);

    // Mixed sizes, CTRL read mid-PROC, then RESULT read right behind a word write
    wr(32'h0, 3'd2, 32'h1, "init_c", 0);
    wr(32'h4, 3'd0, 32'h0000_0031, "b1", 0);
    wr(32'h4, 3'd2, 32'h3534_3332, "w2345", 0);
    rd(32'h0, "ctrl_busy", 32'h0000_0002, 0);
    repeat (4) @(posedge clk);
    #1;
    wr_rd(32'h3938_3736, "w6789_result", 32'hCBF4_3926, 4);

    // Error responses leave state alone
    err(1'b1, 32'h8, 3'd2, "err_wr_result");
    err(1'b1, 32'h5, 3'd1, "err_half_mis");
    err(1'b1, 32'h6, 3'd2, "err_word_mis");
    err(1'b1, 32'hC, 3'd3, "err_size3");
    rd(32'h8, "result_after_err", 32'hCBF4_3926, 0);
    rd(32'hC, "seed_after_err", 32'hFFFF_FFFF, 0);

    // SEED access, halfword lane merge, INIT from SEED
    wr(32'hC, 3'd2, 32'h1234_5678, "seed_wr", 0);
    rd(32'hC, "seed_rd", 32'h1234_5678, 0);
    wr(32'h0, 3'd2, 32'h1, "init_seed", 0);
    rd(32'h8, "result_init", 32'hEDCB_A987, 0);
    wr(32'hE, 3'd1, 32'hABCD_0000, "seed_half", 0);
    rd(32'hC, "seed_half_rd", 32'hABCD_5678, 0);

`ifdef AHB_CRC32_IRQ_EN
    wr(32'h0, 3'd2, 32'h4, "irq_clr0", 0);
    cmp("irq.cleared0", {31'h0, crc_irq}, 32'd0);
    wr(32'h4, 3'd2, 32'hDEAD_BEEF, "irq_word", 0);
    repeat (5) @(posedge clk);
    #1;
    cmp("irq.set", {31'h0, crc_irq}, 32'd1);
    wr(32'h0, 3'd2, 32'h4, "irq_clr1", 0);
    cmp("irq.cleared1", {31'h0, crc_irq}, 32'd0);
`endif

    // Reset during the second PROC cycle
    wr(32'h4, 3'd2, 32'h1122_3344, "w_before_rst", 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    cmp("midrst.hreadyout", {31'h0, hreadyout}, 32'd1);
    cmp("midrst.hresp", {31'h0, hresp}, 32'd0);
    cmp("midrst.hrdata", hrdata, 32'h0);
`ifdef AHB_CRC32_IRQ_EN
    cmp("midrst.irq", {31'h0, crc_irq}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(32'h8, "result_after_rst", 32'h0000_0000, 0);
    rd(32'hC, "seed_after_rst", 32'hFFFF_FFFF, 0);
    rd(32'h0, "ctrl_after_rst", 32'h0000_0000, 0);

    repeat (2) @(posedge clk);
    #1;
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
